uart_fifo_ext: RTL and testbench
================================

UART_FIFO_EXT -- requirements
Module: uart_fifo_ext

Interface
REQ-001 SHALL take parameter WIDTH, default 9: data word width in bits.
REQ-002 SHALL take parameter DEPTH, default 128: entry count; power of 2 and >= 2.
REQ-003 SHALL take parameter FWFT, default 0: 0 = registered read (1-cycle latency); 1 = first-word-fall-through.
REQ-004 SHALL take parameter AFULL_THRESH, default DEPTH-4: o_almost_full threshold; range 1..DEPTH.
REQ-005 SHALL take parameter AEMPTY_THRESH, default 4: o_almost_empty threshold; range 0..DEPTH-1.
REQ-006 SHALL define L = $clog2(DEPTH)+1 as the level width.
REQ-007 SHALL provide i_clk  in  1  single clock; all logic on its rising edge.
REQ-008 SHALL provide i_rst  in  1  reset; synchronous, active-high.
REQ-009 SHALL provide i_flush  in  1  synchronous discard of all contents.
REQ-010 SHALL provide i_wr_en  in  1  push request.
REQ-011 SHALL provide i_wr_data  in  WIDTH  push data.
REQ-012 SHALL provide i_rd_en  in  1  pop request (FWFT=1: acknowledge of the presented head).
REQ-013 SHALL provide o_rd_data  out  WIDTH  read data.
REQ-014 SHALL provide o_rd_valid  out  1  o_rd_data qualifier.
REQ-015 SHALL provide o_empty, o_full, o_almost_empty, o_almost_full  out  1 each  status flags.
REQ-016 SHALL provide o_level  out  L  current occupancy, 0..DEPTH.
REQ-017 SHALL provide o_overflow, o_underflow  out  1 each  sticky error flags.
REQ-018 SHALL provide i_clr_err  in  1  clears both sticky flags.

Function
REQ-019 SHALL derive all status flags from the registered level only; no combinational path from i_wr_en or i_rd_en to any flag.
REQ-020 SHALL assert o_empty when level == 0 and o_full when level == DEPTH.
REQ-021 SHALL assert o_almost_full when level >= AFULL_THRESH and o_almost_empty when level <= AEMPTY_THRESH.
REQ-022 SHALL force o_full and o_almost_full to 0 in any cycle where i_rst is high.
REQ-023 SHALL define accepted write = i_wr_en and (not full, or accepted read in the same cycle).
REQ-024 SHALL define accepted read = i_rd_en and not empty.
REQ-025 SHALL, on an accepted write, store i_wr_data at wr_ptr and advance wr_ptr modulo DEPTH; a write while full without a simultaneous accepted read SHALL be dropped with RAM, pointer and level unchanged.
REQ-026 SHALL, on an accepted read, advance rd_ptr modulo DEPTH; a read while empty SHALL leave the pointer unchanged.
REQ-027 SHALL update level as follows: +1 on accepted write only; -1 on accepted read only; unchanged when both or neither occur.
REQ-028 SHALL, when full and i_wr_en and i_rd_en are asserted together, accept both; level stays DEPTH.
REQ-029 SHALL, when empty and i_wr_en and i_rd_en are asserted together, accept the write, reject the read, and set level to 1.
REQ-030 SHALL, for FWFT=0, register o_rd_data <= ram[rd_ptr] on an accepted read and pulse o_rd_valid high for exactly the next cycle; otherwise o_rd_valid = 0 and o_rd_data holds.
REQ-031 SHALL, for FWFT=1, drive o_rd_data = ram[rd_ptr] and o_rd_valid = not empty continuously; a word written into an empty FIFO SHALL be presented on the cycle after the write.
REQ-032 SHALL set o_overflow on any i_wr_en that is not accepted and set o_underflow on any i_rd_en while empty.
REQ-033 SHALL hold both sticky flags until i_clr_err or i_rst; when i_clr_err coincides with a new error, the error SHALL win and the flag stays set.
REQ-034 SHALL, on i_flush, zero wr_ptr, rd_ptr and level and force o_rd_valid to 0; flush SHALL take priority over same-cycle i_wr_en and i_rd_en, which are ignored and set no error flags.
REQ-035 SHALL leave sticky flags and RAM contents unchanged on i_flush.

Reset
REQ-036 SHALL, while i_rst is high, zero wr_ptr, rd_ptr, level, o_rd_valid, o_overflow and o_underflow, and ignore i_wr_en, i_rd_en and i_flush.
REQ-037 SHALL, after reset, present o_empty = 1, o_almost_empty = 1, o_full = 0, o_almost_full = 0 and o_level = 0.
REQ-038 SHALL keep o_rd_data and RAM contents undefined after reset; a reset mid-operation SHALL discard all stored words.

Verification
REQ-039 SHALL verify, with FWFT=0 and DEPTH=4: write 0x11, 0x22, 0x33, then read 3 times -> data 0x11, 0x22, 0x33, each with o_rd_valid one cycle after its i_rd_en, and o_empty = 1 at the end.
REQ-040 SHALL verify, with DEPTH=4: 5 writes -> o_full = 1, o_level = 4, 5th write dropped, o_overflow = 1; then i_clr_err -> o_overflow = 0.
REQ-041 SHALL verify, with DEPTH=4 full: i_wr_en and i_rd_en asserted together for 8 cycles -> o_level stays 4, no error flags, data order preserved across pointer wrap-around.
REQ-042 SHALL verify, with the FIFO empty: i_rd_en together with i_wr_en=0xAB -> o_underflow = 1, o_rd_valid = 0, o_level = 1; with FWFT=1, o_rd_data = 0xAB and o_rd_valid = 1 on the next cycle.
REQ-043 SHALL verify, with DEPTH=8, AFULL_THRESH=6, AEMPTY_THRESH=2: fill 0 to 8 -> o_almost_empty high at levels 0..2 and o_almost_full high at levels 6..8.
REQ-044 SHALL verify: 3 words stored, then i_flush together with i_wr_en -> o_level = 0, o_empty = 1, write ignored, error flags unchanged; i_rst mid-fill -> all outputs at their reset values the next cycle.

Source files
------------

// File: rtl/uart_fifo_ext.sv
// Synchronous single-clock FIFO with level-derived status flags, sticky error flags and flush.
// Reads are registered (1-cycle latency) or first-word-fall-through, and a write into a full FIFO is accepted only when a read frees a slot in the same cycle.
module uart_fifo_ext #(
    parameter int WIDTH         = 9,
    parameter int DEPTH         = 128,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 4,
    parameter int AEMPTY_THRESH = 4,
    localparam int L            = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_rd_valid,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_almost_empty,
    output logic             o_almost_full,
    output logic [L-1:0]     o_level,
    output logic             o_overflow,
    output logic             o_underflow,
    input  logic             i_clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [L-1:0] LVL_FULL = L'(DEPTH);
    localparam logic [L-1:0] LVL_AF   = L'(AFULL_THRESH);
    localparam logic [L-1:0] LVL_AE   = L'(AEMPTY_THRESH);

    logic [WIDTH-1:0] ram [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [L-1:0]     level;
    logic             empty;
    logic             full;
    logic             rd_acc;
    logic             wr_acc;
    logic             overflow_q;
    logic             underflow_q;

    // Flags come only from the registered level; only reset may mask them.
    assign empty = (level == '0);
    assign full  = (level == LVL_FULL);

    always_comb begin
        rd_acc = i_rd_en & ~empty;
        wr_acc = i_wr_en & (~full | rd_acc);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + L'(1);
                2'b01:   level <= level - L'(1);
                default: level <= level;
            endcase
        end
    end

    // A new error in the same cycle as a clear keeps the flag set.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (!i_flush) begin
            if (i_wr_en && !wr_acc)  overflow_q <= 1'b1;
            else if (i_clr_err)      overflow_q <= 1'b0;
            if (i_rd_en && empty)    underflow_q <= 1'b1;
            else if (i_clr_err)      underflow_q <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_flush && wr_acc) ram[wr_ptr] <= i_wr_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign o_rd_data  = ram[rd_ptr];
            assign o_rd_valid = ~empty & ~i_rst & ~i_flush;
        end else begin : g_reg
            logic [WIDTH-1:0] rd_data_q;
            logic             rd_valid_q;

            always_ff @(posedge i_clk) begin
                if (i_rst || i_flush) begin
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) rd_data_q <= ram[rd_ptr];
                end
            end

            assign o_rd_data  = rd_data_q;
            assign o_rd_valid = rd_valid_q;
        end
    endgenerate

    assign o_empty        = empty;
    assign o_full         = full & ~i_rst;
    assign o_almost_empty = (level <= LVL_AE);
    assign o_almost_full  = (level >= LVL_AF) & ~i_rst;
    assign o_level        = level;
    assign o_overflow     = overflow_q;
    assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_uart_fifo_ext.sv
// Directed bench: a depth-4 registered FIFO, a depth-4 FWFT FIFO and a depth-8 threshold FIFO share stimulus.
module tb_uart_fifo_ext;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [8:0] wr_data = '0;

    always #5 clk = ~clk;

    logic [8:0] a_data, b_data, c_data;
    logic       a_rv, a_emp, a_ful, a_ae, a_af, a_ovf, a_udf;
    logic       b_rv, b_emp, b_ful, b_ae, b_af, b_ovf, b_udf;
    logic       c_rv, c_emp, c_ful, c_ae, c_af, c_ovf, c_udf;
    logic [2:0] a_lvl, b_lvl;
    logic [3:0] c_lvl;

    uart_fifo_ext #(.WIDTH(9), .DEPTH(4), .FWFT(0), .AFULL_THRESH(3), .AEMPTY_THRESH(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_wr_en(wr_en), .i_wr_data(wr_data),
        .i_rd_en(rd_en), .o_rd_data(a_data), .o_rd_valid(a_rv), .o_empty(a_emp), .o_full(a_ful),
        .o_almost_empty(a_ae), .o_almost_full(a_af), .o_level(a_lvl), .o_overflow(a_ovf),
        .o_underflow(a_udf), .i_clr_err(clr_err));

    uart_fifo_ext #(.WIDTH(9), .DEPTH(4), .FWFT(1), .AFULL_THRESH(3), .AEMPTY_THRESH(1)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_wr_en(wr_en), .i_wr_data(wr_data),
        .i_rd_en(rd_en), .o_rd_data(b_data), .o_rd_valid(b_rv), .o_empty(b_emp), .o_full(b_ful),
        .o_almost_empty(b_ae), .o_almost_full(b_af), .o_level(b_lvl), .o_overflow(b_ovf),
        .o_underflow(b_udf), .i_clr_err(clr_err));

    uart_fifo_ext #(.WIDTH(9), .DEPTH(8), .FWFT(0), .AFULL_THRESH(6), .AEMPTY_THRESH(2)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_wr_en(wr_en), .i_wr_data(wr_data),
        .i_rd_en(rd_en), .o_rd_data(c_data), .o_rd_valid(c_rv), .o_empty(c_emp), .o_full(c_ful),
        .o_almost_empty(c_ae), .o_almost_full(c_af), .o_level(c_lvl), .o_overflow(c_ovf),
        .o_underflow(c_udf), .i_clr_err(clr_err));

    typedef struct {
        logic       wr, rd, fl, clr;
        logic [8:0] din;
        logic [2:0] lvl;
        logic       emp, ful, rv;
        logic [8:0] dout;
        logic       ovf, udf;
    } vec_t;

    vec_t tv[$];
    int   n_chk = 0;
    int   n_err = 0;

    function automatic vec_t v(input logic wr, input logic rd, input logic fl, input logic clr,
                               input logic [8:0] din, input logic [2:0] lvl, input logic emp,
                               input logic ful, input logic rv, input logic [8:0] dout,
                               input logic ovf, input logic udf);
        vec_t r;
        r.wr = wr; r.rd = rd; r.fl = fl; r.clr = clr; r.din = din; r.lvl = lvl;
        r.emp = emp; r.ful = ful; r.rv = rv; r.dout = dout; r.ovf = ovf; r.udf = udf;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic rd, input logic fl, input logic clr,
                         input logic [8:0] din);
        wr_en = wr; rd_en = rd; flush = fl; clr_err = clr; wr_data = din;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        drive(0, 0, 0, 0, 9'h0);
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    logic [8:0] ae_exp, af_exp, full_exp;

    initial begin
        // Registered-read behaviour: ordering, full/overflow, wrap with simultaneous push/pop, underflow vs clear.
        tv.push_back(v(1,0,0,0,9'h011, 1,0,0,0,9'h000,0,0));
        tv.push_back(v(1,0,0,0,9'h022, 2,0,0,0,9'h000,0,0));
        tv.push_back(v(1,0,0,0,9'h033, 3,0,0,0,9'h000,0,0));
        tv.push_back(v(0,1,0,0,9'h000, 2,0,0,1,9'h011,0,0));
        tv.push_back(v(0,1,0,0,9'h000, 1,0,0,1,9'h022,0,0));
        tv.push_back(v(0,1,0,0,9'h000, 0,1,0,1,9'h033,0,0));
        tv.push_back(v(0,0,0,0,9'h000, 0,1,0,0,9'h000,0,0));
        tv.push_back(v(1,0,0,0,9'h001, 1,0,0,0,9'h000,0,0));
        tv.push_back(v(1,0,0,0,9'h002, 2,0,0,0,9'h000,0,0));
        tv.push_back(v(1,0,0,0,9'h003, 3,0,0,0,9'h000,0,0));
        tv.push_back(v(1,0,0,0,9'h004, 4,0,1,0,9'h000,0,0));
        tv.push_back(v(1,0,0,0,9'h005, 4,0,1,0,9'h000,1,0));
        tv.push_back(v(0,0,0,1,9'h000, 4,0,1,0,9'h000,0,0));
        for (int k = 0; k < 8; k++)
            tv.push_back(v(1,1,0,0,9'(16+k), 4,0,1,1, (k < 4) ? 9'(k+1) : 9'(12+k), 0,0));
        tv.push_back(v(0,1,0,0,9'h000, 3,0,0,1,9'h014,0,0));
        tv.push_back(v(0,1,0,0,9'h000, 2,0,0,1,9'h015,0,0));
        tv.push_back(v(0,1,0,0,9'h000, 1,0,0,1,9'h016,0,0));
        tv.push_back(v(0,1,0,0,9'h000, 0,1,0,1,9'h017,0,0));
        tv.push_back(v(0,1,0,1,9'h000, 0,1,0,0,9'h000,0,1));
        tv.push_back(v(0,0,0,1,9'h000, 0,1,0,0,9'h000,0,0));
        tv.push_back(v(0,0,0,0,9'h000, 0,1,0,0,9'h000,0,0));

        do_reset;
        chk("rst_level", a_lvl, 0);
        chk("rst_empty", a_emp, 1);
        chk("rst_aempty", a_ae, 1);
        chk("rst_full", a_ful, 0);
        chk("rst_afull", a_af, 0);
        chk("rst_rvalid", a_rv, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_udf", a_udf, 0);
        chk("rst_b_rvalid", b_rv, 0);
        chk("rst_c_afull", c_af, 0);

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].wr, tv[i].rd, tv[i].fl, tv[i].clr, tv[i].din);
            tick;
            chk($sformatf("v%0d_level", i), a_lvl, tv[i].lvl);
            chk($sformatf("v%0d_empty", i), a_emp, tv[i].emp);
            chk($sformatf("v%0d_full", i), a_ful, tv[i].ful);
            chk($sformatf("v%0d_rvalid", i), a_rv, tv[i].rv);
            chk($sformatf("v%0d_ovf", i), a_ovf, tv[i].ovf);
            chk($sformatf("v%0d_udf", i), a_udf, tv[i].udf);
            if (tv[i].rv) chk($sformatf("v%0d_rdata", i), a_data, tv[i].dout);
        end

        // Simultaneous push/pop on an empty FIFO: write wins, read underflows.
        do_reset;
        drive(1, 1, 0, 0, 9'h0AB);
        tick;
        drive(0, 0, 0, 0, 9'h000);
        chk("ew_a_udf", a_udf, 1);
        chk("ew_a_rvalid", a_rv, 0);
        chk("ew_a_level", a_lvl, 1);
        chk("ew_b_rvalid", b_rv, 1);
        chk("ew_b_rdata", b_data, 9'h0AB);
        chk("ew_b_udf", b_udf, 1);
        chk("ew_b_level", b_lvl, 1);

        // Threshold flags across every level of the depth-8 instance.
        do_reset;
        ae_exp   = 9'b000000111;
        af_exp   = 9'b111000000;
        full_exp = 9'b100000000;
        for (int lv = 0; lv <= 8; lv++) begin
            if (lv > 0) begin
                drive(1, 0, 0, 0, 9'(lv));
                tick;
            end
            chk($sformatf("th%0d_level", lv), c_lvl, lv);
            chk($sformatf("th%0d_aempty", lv), c_ae, ae_exp[lv]);
            chk($sformatf("th%0d_afull", lv), c_af, af_exp[lv]);
            chk($sformatf("th%0d_full", lv), c_ful, full_exp[lv]);
        end
        drive(0, 0, 0, 0, 9'h000);

        // Flush priority over same-cycle push/pop; sticky flags survive it.
        do_reset;
        drive(0, 1, 0, 0, 9'h000);
        tick;
        chk("fl_pre_udf", a_udf, 1);
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, 9'(9'h041 + k));
            tick;
        end
        drive(0, 1, 0, 0, 9'h000);
        tick;
        chk("fl_pre_rvalid", a_rv, 1);
        chk("fl_pre_rdata", a_data, 9'h041);
        drive(1, 1, 1, 0, 9'h1FF);
        tick;
        chk("fl_level", a_lvl, 0);
        chk("fl_empty", a_emp, 1);
        chk("fl_rvalid", a_rv, 0);
        chk("fl_udf_kept", a_udf, 1);
        chk("fl_ovf_kept", a_ovf, 0);
        drive(0, 0, 0, 0, 9'h000);
        tick;
        chk("fl_write_ignored", a_lvl, 0);

        // Reset mid-operation: full flags masked during reset, everything cleared after the edge.
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 0, 9'(9'h060 + k));
            tick;
        end
        chk("mr_full", a_ful, 1);
        drive(1, 1, 0, 0, 9'h070);
        tick;
        chk("mr_rvalid_pre", a_rv, 1);
        rst = 1'b1;
        #1;
        chk("mr_full_masked", a_ful, 0);
        chk("mr_afull_masked", a_af, 0);
        tick;
        chk("mr_level", a_lvl, 0);
        chk("mr_empty", a_emp, 1);
        chk("mr_aempty", a_ae, 1);
        chk("mr_full_after", a_ful, 0);
        chk("mr_afull_after", a_af, 0);
        chk("mr_rvalid", a_rv, 0);
        chk("mr_udf", a_udf, 0);
        chk("mr_ovf", a_ovf, 0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 9'h000);
        tick;
        chk("mr_level_hold", a_lvl, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
